// File: rtl/mat_mult_seq_if.sv
// Handshake and operand/result bus for mat_mult_seq.
// master = requester driving operands, slave = the multiplier.
interface mat_mult_seq_if #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 27
);
  logic                       start;
  logic                       mode;
  logic                       en;
  logic                       ready;
  logic                       done;
  logic [N-1:0][N-1:0][W-1:0] dataa;
  logic [N-1:0][N-1:0][W-1:0] datab;
  logic [N-1:0][N-1:0][W-1:0] result;

  modport master (output start, mode, en, dataa, datab,
                  input  ready, done, result);
  modport slave  (input  start, mode, en, dataa, datab,
                  output ready, done, result);
endinterface

// File: rtl/mat_mult_seq.sv
// Sequential NxN signed matrix multiplier (mode=1, one k step per enabled cycle)
// and element-wise multiplier (mode=0). Define MAT_MULT_SEQ_SAT_EN to saturate results.
module mat_mult_seq #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 27
) (
  input logic           clk,
  input logic           rst_n,
  mat_mult_seq_if.slave bus
);
  localparam int unsigned ACC_W = 2*W + $clog2(N);
  localparam int unsigned K_W   = (N > 1) ? $clog2(N) : 1;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  state_t                  r_state, w_state_next;
  mat_t                    r_a, r_b, r_result;
  logic                    r_mode, r_ready, r_done;
  logic [K_W-1:0]          r_k, w_k_next;
  logic signed [ACC_W-1:0] r_acc      [N][N];
  logic signed [ACC_W-1:0] w_acc_next [N][N];
  logic                    w_load;

  // Full-precision signed product of two W-bit elements.
  function automatic logic signed [ACC_W-1:0] mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic signed [ACC_W-1:0] xe;
    logic signed [ACC_W-1:0] ye;
    xe = ACC_W'($signed(x));
    ye = ACC_W'($signed(y));
    return xe * ye;
  endfunction

`ifdef MAT_MULT_SEQ_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  function automatic logic [W-1:0] narrow(input logic signed [ACC_W-1:0] acc);
    if (acc > SAT_MAX)      return W'(SAT_MAX);
    else if (acc < SAT_MIN) return W'(SAT_MIN);
    else                    return W'(acc);
  endfunction
`else
  function automatic logic [W-1:0] narrow(input logic signed [ACC_W-1:0] acc);
    return W'(acc);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state, k step and accumulator update.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_acc_next   = r_acc;
    w_load       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_COMPUTE;
          w_k_next     = '0;
          w_load       = 1'b1;
        end
      end
      S_COMPUTE: begin
        if (bus.en) begin
          if (r_mode) begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                w_acc_next[i][j] = ((r_k == '0) ? '0 : r_acc[i][j]) + mul(r_a[i][r_k], r_b[r_k][j]);
              end
            end
            if (r_k == K_W'(N-1)) w_state_next = S_DONE;
            else                  w_k_next     = r_k + K_W'(1);
          end else begin
            for (int i = 0; i < N; i++) begin
              for (int j = 0; j < N; j++) begin
                w_acc_next[i][j] = mul(r_a[i][j], r_b[i][j]);
              end
            end
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath registers; result is loaded from the final accumulator on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k      <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_a      <= '0;
      r_b      <= '0;
      r_mode   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      r_k     <= w_k_next;
      r_acc   <= w_acc_next;
      r_done  <= (w_state_next == S_DONE);
      r_ready <= (w_state_next == S_IDLE);
      if (w_load) begin
        r_a    <= bus.dataa;
        r_b    <= bus.datab;
        r_mode <= bus.mode;
      end
      if (r_state == S_COMPUTE && w_state_next == S_DONE) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            r_result[i][j] <= narrow(w_acc_next[i][j]);
          end
        end
      end
    end
  end

  assign bus.ready  = r_ready;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_mat_mult_seq.sv
// Self-checking bench for mat_mult_seq at N=2, W=8: vector table, stall,
// busy-start and mid-operation reset sequences, honouring MAT_MULT_SEQ_SAT_EN.
module tb_mat_mult_seq;
  localparam int unsigned N = 2;
  localparam int unsigned W = 8;

  typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
  typedef struct { mat_t a; mat_t b; logic mode; mat_t exp; } vec_t;
  typedef struct { mat_t res; int lat; } exp_t;

`ifdef MAT_MULT_SEQ_SAT_EN
  localparam int POS_OVF = 127;
  localparam int NEG_OVF = -128;
  localparam int SQ_OVF  = 127;
`else
  localparam int POS_OVF = 2;
  localparam int NEG_OVF = 0;
  localparam int SQ_OVF  = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mat_mult_seq_if #(.N(N), .W(W)) bus ();
  mat_mult_seq #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  exp_t sbq[$];
  vec_t vecs[6];

  function automatic mat_t mk(input int v00, input int v01, input int v10, input int v11);
    mat_t m;
    m[0][0] = 8'(v00); m[0][1] = 8'(v01);
    m[1][0] = 8'(v10); m[1][1] = 8'(v11);
    return m;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One operation through the scoreboard; optional en=0 window with ignored start pulses.
  task automatic run_op(input mat_t a, input mat_t b, input logic mode, input mat_t exp,
                        input int stall_at, input int stall_len, input string name);
    exp_t e;
    mat_t prev;
    int   edges;
    logic seen_done, held;
    e.res = exp;
    e.lat = (mode ? N + 1 : 2) + stall_len;
    sbq.push_back(e);
    @(negedge clk);
    bus.dataa = a; bus.datab = b; bus.mode = mode; bus.start = 1'b1; bus.en = 1'b1;
    @(posedge clk); #1;
    prev = bus.result;
    edges = 0; seen_done = 1'b0; held = 1'b1;
    while (!seen_done && edges < 40) begin
      @(negedge clk);
      bus.dataa = $urandom;
      bus.datab = $urandom;
      bus.mode  = ~mode;
      bus.en    = !((edges + 1 >= stall_at) && (edges + 1 < stall_at + stall_len));
      bus.start = !bus.en;
      @(posedge clk); #1;
      edges++;
      if (bus.done) seen_done = 1'b1;
      else if (bus.result !== prev) held = 1'b0;
    end
    bus.start = 1'b0;
    bus.en    = 1'b1;
    e = sbq.pop_front();
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, required latency %0d", name, edges, e.lat);
    end else begin
      check({name, "_latency"}, 32'(edges + 1), 32'(e.lat));
      check({name, "_result"}, bus.result, e.res);
    end
    check({name, "_result_held"}, 32'(held), 32'd1);
    @(posedge clk); #1;
    check({name, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({name, "_ready_after"}, 32'(bus.ready), 32'd1);
  endtask

  initial begin
    logic no_done;
    vecs[0] = '{mk(1,2,3,4),         mk(5,6,7,8),         1'b1, mk(19,22,43,50)};
    vecs[1] = '{mk(1,2,3,4),         mk(5,6,7,8),         1'b0, mk(5,12,21,32)};
    vecs[2] = '{mk(127,127,127,127), mk(127,127,127,127), 1'b1, mk(POS_OVF,POS_OVF,POS_OVF,POS_OVF)};
    vecs[3] = '{mk(-128,-128,-128,-128), mk(127,127,127,127), 1'b1, mk(NEG_OVF,NEG_OVF,NEG_OVF,NEG_OVF)};
    vecs[4] = '{mk(-128,-128,-128,-128), mk(-128,-128,-128,-128), 1'b0, mk(SQ_OVF,SQ_OVF,SQ_OVF,SQ_OVF)};
    vecs[5] = '{mk(-1,2,3,-4),       mk(5,-6,7,8),        1'b1, mk(9,22,-13,-50)};

    rst_n = 1'b0; bus.start = 1'b1; bus.mode = 1'b1; bus.en = 1'b1;
    bus.dataa = mk(1,2,3,4); bus.datab = mk(5,6,7,8);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    check("reset_ready", 32'(bus.ready), 32'd1);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", bus.result, 32'd0);

    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].a, vecs[v].b, vecs[v].mode, vecs[v].exp, 0, 0, $sformatf("vec%0d", v));
    end

    run_op(vecs[0].a, vecs[0].b, 1'b1, vecs[0].exp, 2, 3, "stall");

    // Reset asserted two cycles into a matrix product.
    @(negedge clk);
    bus.dataa = vecs[0].a; bus.datab = vecs[0].b; bus.mode = 1'b1; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; bus.start = 1'b0;
    @(posedge clk); #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_result", bus.result, 32'd0);
    no_done = !bus.done;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (bus.done) no_done = 1'b0;
    end
    check("abort_no_done", 32'(no_done), 32'd1);

    run_op(vecs[0].a, vecs[0].b, 1'b1, vecs[0].exp, 0, 0, "after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mat_mult_seq.md
MAT_MULT_SEQ -- requirements
Module: mat_mult_seq

Interface
REQ-001 Parameter N, default 2, matrix dimension (legal range 1..8).
REQ-002 Parameter W, default 27, signed operand and result element width.
REQ-003 Derived localparam ACC_W = 2*W + $clog2(N), internal accumulator width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request a new operation; sampled only while ready=1.
REQ-007 mode  input  1  0 = element-wise (parallel multiplier), 1 = matrix product; sampled with start.
REQ-008 en  input  1  compute enable; en=0 stalls the COMPUTE state.
REQ-009 dataa  input  [N][N][W]  operand A, dataa[i][j] = row i, column j, signed.
REQ-010 datab  input  [N][N][W]  operand B, same layout, signed.
REQ-011 ready  output  1  high only in IDLE.
REQ-012 done  output  1  one-cycle pulse; result valid from this cycle.
REQ-013 result  output  [N][N][W]  registered result matrix, signed.

Function
REQ-014 States IDLE, COMPUTE, DONE; only IDLE accepts start.
REQ-015 IDLE with start=1: latch dataa, datab, mode into internal registers; clear k counter; go to COMPUTE.
REQ-016 start while not in IDLE is ignored, with no effect on latched operands or progress.
REQ-017 Inputs dataa/datab may change freely after the start cycle without affecting the operation.
REQ-018 COMPUTE with en=0: acc, k and state hold.
REQ-019 COMPUTE, mode=1, en=1: acc[i][j] <= (k==0 ? 0 : acc[i][j]) + A[i][k]*B[k][j], full ACC_W signed precision, all N*N elements in parallel.
REQ-020 mode=1: k increments 0..N-1; on the k=N-1 enabled cycle go to DONE.
REQ-021 COMPUTE, mode=0, en=1: acc[i][j] <= A[i][j]*B[i][j]; go to DONE after one enabled cycle.
REQ-022 Entering DONE: result <= narrow(acc) (see REQ-029/030); done=1 for exactly that cycle; next state IDLE.
REQ-023 Latency with en held high: start sampled at cycle t, done at t+N+1 (mode=1) or t+2 (mode=0); each en=0 COMPUTE cycle adds one.
REQ-024 result holds its value from done until the next DONE; it is unchanged while IDLE or COMPUTE.
REQ-025 N=1, mode=1 behaves identically to mode=0.

Reset
REQ-026 rst_n=0 at any clock edge, including mid-COMPUTE: state <= IDLE, k <= 0, acc <= 0, result <= 0, done <= 0.
REQ-027 ready=1 on the first cycle after reset release; the aborted operation produces no done.
REQ-028 Reset takes priority over start and en in the same cycle.

Configuration
REQ-029 Macro MAT_MULT_SEQ_SAT_EN defined: narrow() saturates acc to [-2^(W-1), 2^(W-1)-1].
REQ-030 Macro MAT_MULT_SEQ_SAT_EN undefined: narrow() truncates to acc[W-1:0] (two's-complement wrap).

Verification (N=2, W=8)
REQ-031 A=[[1,2],[3,4]], B=[[5,6],[7,8]], mode=1, en=1 -> done at t+3, result=[[19,22],[43,50]], ready high at t+4.
REQ-032 Same A, B, mode=0 -> done at t+2, result=[[5,12],[21,32]].
REQ-033 A=all 127, B=all 127, mode=1 -> result all 127 with SAT_EN, all 2 without. A=all -128, B=all 127 -> all -128 with SAT_EN, all 0 without.
REQ-034 mode=1 start; en=0 for 3 cycles mid-COMPUTE -> done at t+6, result identical to REQ-031; start pulses while busy ignored.
REQ-035 rst_n=0 at t+2 of a mode=1 operation -> no done, result=0, ready=1 after release; a following REQ-031 operation completes correctly.
